// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic neg, input logic ovf,
                                                   input logic carry, input logic zero);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = neg;
    f[FLAG_V] = ovf;
    f[FLAG_C] = carry;
    f[FLAG_Z] = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles per
// product. done_o flags the final iteration cycle; prod_o then carries the finished product.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign prod_o = prod_d;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      prod_q   <= '0;
      mplier_q <= b_i;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      busy_q   <= (cnt_q != CW'(1));
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshakes, an accumulator usable as operand A and an
// iterative multiplier; single-cycle ops complete on the accept edge.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_e               op,
  input  logic              acc_sel,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  res_lo,
  output logic [WIDTH-1:0]  res_hi,
  output logic [FLAG_W-1:0] flags
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_lo_q;
  logic [WIDTH-1:0]   res_hi_q;
  logic [FLAG_W-1:0]  flags_q;
  logic [WIDTH-1:0]   acc_q;

  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   alu_lo;
  logic               alu_c;
  logic               alu_v;
  logic [FLAG_W-1:0]  alu_flags;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [FLAG_W-1:0]  mul_flags;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign op_a     = acc_sel ? acc_q : a;
  assign shamt    = b[SW-1:0];

  // Extended operands expose carry/borrow and the last bit shifted out at bit WIDTH / bit 0.
  assign add_ext = {1'b0, op_a} + {1'b0, b};
  assign sub_ext = {1'b0, op_a} - {1'b0, b};
  assign shl_ext = {1'b0, op_a} << shamt;
  assign shr_ext = {op_a, 1'b0} >> shamt;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    alu_lo = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_lo = add_ext[WIDTH-1:0];
        alu_c  = add_ext[WIDTH];
        alu_v  = (op_a[MSB] == b[MSB]) && (alu_lo[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_lo = sub_ext[WIDTH-1:0];
        alu_c  = sub_ext[WIDTH];
        alu_v  = (op_a[MSB] != b[MSB]) && (alu_lo[MSB] != op_a[MSB]);
      end
      OP_AND: alu_lo = op_a & b;
      OP_OR:  alu_lo = op_a | b;
      OP_XOR: alu_lo = op_a ^ b;
      OP_SHL: begin
        alu_lo = shl_ext[WIDTH-1:0];
        alu_c  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_lo = shr_ext[WIDTH:1];
        alu_c  = shr_ext[0];
      end
      default: ;
    endcase
  end

  assign alu_flags = pack_flags(alu_lo[MSB], alu_v, alu_c, alu_lo == '0);
  assign mul_flags = pack_flags(mul_prod[2*WIDTH-1], 1'b0,
                                mul_prod[2*WIDTH-1:WIDTH] != '0, mul_prod == '0);

  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (op_a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q     <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              out_valid_q <= 1'b1;
              res_lo_q    <= alu_lo;
              res_hi_q    <= '0;
              flags_q     <= alu_flags;
              acc_q       <= alu_lo;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            res_lo_q    <= mul_prod[WIDTH-1:0];
            res_hi_q    <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q     <= mul_flags;
            acc_q       <= mul_prod[WIDTH-1:0];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;
  assign flags     = flags_q;

endmodule
